// File: rtl/acc_pkg.sv
// Shared FSM encodings and saturation bounds for the accumulator bank.
package acc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int SAT_FN_W = 128;

    // Largest signed value representable in w bits, returned zero-extended.
    function automatic logic [SAT_FN_W-1:0] sat_max(input int w);
        return (SAT_FN_W'(1) << (w - 1)) - SAT_FN_W'(1);
    endfunction

    // Smallest signed value in w bits; truncate the result to w bits.
    function automatic logic [SAT_FN_W-1:0] sat_min(input int w);
        return SAT_FN_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulation lane: entry storage, write pointer, pass counter, adder and
// sticky overflow flag. Macro ACC_BANK_SAT_EN selects clamping instead of wrap.
module acc_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int DEPTH      = 64,
    parameter int PASS_WIDTH = 8,
    parameter int LEN_W      = 7,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] psum_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [PASS_WIDTH-1:0] num_pass_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [ACC_WIDTH-1:0]  rd_data_o,
    output logic                  done_o,
    output logic                  ovf_o
);
    import acc_pkg::*;

`ifdef ACC_BANK_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
`endif

    logic [ACC_WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0]     wp_q, wp_d;
    logic [PASS_WIDTH-1:0] pass_q, pass_d;
    logic                  ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]  psum_ext;
    logic [ACC_WIDTH-1:0]  stored;
    logic [ACC_WIDTH-1:0]  wr_data;
    logic [ACC_WIDTH:0]    sum_wide;
    logic [LEN_W-1:0]      len_m1;
    logic                  sum_ovf;
    logic                  wr_en;

    assign psum_ext  = ACC_WIDTH'($signed(psum_i));
    assign stored    = mem_q[wp_q];
    // One guard bit: overflow shows up as disagreement of the top two bits.
    assign sum_wide  = {stored[ACC_WIDTH-1], stored} + {psum_ext[ACC_WIDTH-1], psum_ext};
    assign sum_ovf   = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign len_m1    = len_i - LEN_W'(1);
    assign done_o    = (pass_q == num_pass_i);
    assign wr_en     = en_i && !done_o;
    assign rd_data_o = mem_q[rd_addr_i];
    assign ovf_o     = ovf_q;

    always_comb begin
        wr_data = sum_wide[ACC_WIDTH-1:0];
        if (pass_q == '0) begin
            wr_data = psum_ext;
        end else if (sum_ovf) begin
`ifdef ACC_BANK_SAT_EN
            wr_data = sum_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
`else
            wr_data = sum_wide[ACC_WIDTH-1:0];
`endif
        end
    end

    always_comb begin
        wp_d   = wp_q;
        pass_d = pass_q;
        ovf_d  = ovf_q;
        if (wr_en) begin
            if (LEN_W'(wp_q) == len_m1) begin
                wp_d   = '0;
                pass_d = pass_q + PASS_WIDTH'(1);
            end else begin
                wp_d = wp_q + ADDR_W'(1);
            end
            if ((pass_q != '0) && sum_ovf) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wp_q   <= '0;
            pass_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            pass_q <= pass_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= wr_data;
        end
    end

endmodule

// File: rtl/acc_bank.sv
// Multi-lane partial-sum accumulator with a ready/valid drain port.
// Build with ACC_BANK_SAT_EN defined to saturate instead of wrapping on overflow.
module acc_bank #(
    parameter int PE_SIZE    = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int DEPTH      = 64,
    parameter int PASS_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [PASS_WIDTH-1:0]         num_pass_i,
    input  logic [$clog2(DEPTH+1)-1:0]    len_i,
    input  logic [PE_SIZE-1:0]            psum_en_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] psum_row_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ACC_WIDTH*PE_SIZE-1:0]  psum_row_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [PE_SIZE-1:0]            ovf_o
);
    import acc_pkg::*;

    localparam int LEN_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    logic [1:0]            state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [PASS_WIDTH-1:0] npass_q, npass_d;
    logic [ADDR_W-1:0]     rp_q, rp_d;
    logic                  done_q, done_d;
    logic                  start_ok;
    logic                  all_done;
    logic [LEN_W-1:0]      len_m1;
    logic [PE_SIZE-1:0]    lane_done;
    logic [PE_SIZE-1:0]    lane_ovf;
    logic [ACC_WIDTH-1:0]  lane_rd [PE_SIZE];

    // Drain handshake: a row transfers on any edge where out_valid_o and
    // out_ready_i are both high; the row is held unchanged otherwise.
    assign start_ok    = (state_q == ST_IDLE) && start_i && (len_i != '0) && (len_i <= DEPTH_L);
    assign all_done    = &lane_done;
    assign len_m1      = len_q - LEN_W'(1);
    assign out_valid_o = (state_q == ST_DRAIN);
    assign busy_o      = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    assign done_o      = done_q;
    assign ovf_o       = lane_ovf;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        npass_d = npass_q;
        rp_d    = rp_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_ACCUM;
                    len_d   = len_i;
                    npass_d = (num_pass_i == '0) ? PASS_WIDTH'(1) : num_pass_i;
                    rp_d    = '0;
                end
            end
            ST_ACCUM: begin
                if (all_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready_i) begin
                    if (LEN_W'(rp_q) == len_m1) begin
                        state_d = ST_IDLE;
                        rp_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        rp_d = rp_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            npass_q <= '0;
            rp_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            npass_q <= npass_d;
            rp_q    <= rp_d;
            done_q  <= done_d;
        end
    end

    for (genvar j = 0; j < PE_SIZE; j++) begin : g_lane
        acc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .DEPTH      (DEPTH),
            .PASS_WIDTH (PASS_WIDTH),
            .LEN_W      (LEN_W),
            .ADDR_W     (ADDR_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (start_ok),
            .en_i       ((state_q == ST_ACCUM) && psum_en_i[j]),
            .psum_i     (psum_row_i[(PE_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH]),
            .len_i      (len_q),
            .num_pass_i (npass_q),
            .rd_addr_i  (rp_q),
            .rd_data_o  (lane_rd[j]),
            .done_o     (lane_done[j]),
            .ovf_o      (lane_ovf[j])
        );
    end

    always_comb begin
        psum_row_o = '0;
        if (out_valid_o) begin
            for (int j = 0; j < PE_SIZE; j++) begin
                psum_row_o[(PE_SIZE-1-j)*ACC_WIDTH +: ACC_WIDTH] = lane_rd[j];
            end
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// Directed-vector bench for acc_bank: full-size instance plus a narrow 8-bit one for overflow.
module tb_acc_bank;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic [7:0]   num_pass_i;
    logic [6:0]   len_i;
    logic [15:0]  psum_en_i;
    logic [511:0] psum_row_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [639:0] psum_row_o;
    logic         busy_o;
    logic         done_o;
    logic [15:0]  ovf_o;

    logic         s_start;
    logic [7:0]   s_np;
    logic [2:0]   s_len;
    logic [1:0]   s_en;
    logic [15:0]  s_psum;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_row;
    logic         s_busy;
    logic         s_done;
    logic [1:0]   s_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [39:0] lane_val [16];
    logic [639:0]       exp_row;

    acc_bank dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_pass_i(num_pass_i),
        .len_i(len_i), .psum_en_i(psum_en_i), .psum_row_i(psum_row_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .psum_row_o(psum_row_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
    );

    acc_bank #(.PE_SIZE(2), .DATA_WIDTH(8), .ACC_WIDTH(8), .DEPTH(4), .PASS_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(s_start), .num_pass_i(s_np),
        .len_i(s_len), .psum_en_i(s_en), .psum_row_i(s_psum),
        .out_valid_o(s_valid), .out_ready_i(s_ready),
        .psum_row_o(s_row), .busy_o(s_busy), .done_o(s_done), .ovf_o(s_ovf)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_psum(input int j, input logic [31:0] v);
        psum_row_i[(15-j)*32 +: 32] = v;
    endtask

    task automatic start_job(input logic [6:0] len, input logic [7:0] np);
        start_i = 1'b1; len_i = len; num_pass_i = np;
        tick();
        start_i = 1'b0;
    endtask

    function automatic logic [639:0] pack_row();
        logic [639:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r[(15-j)*40 +: 40] = lane_val[j];
        return r;
    endfunction

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if (busy_o !== 1'b0) begin $display("FAIL reset_busy: got %0b want 0", busy_o); n_fail++; end
        n_checks++;
        if (out_valid_o !== 1'b0) begin $display("FAIL reset_valid: got %0b want 0", out_valid_o); n_fail++; end
        n_checks++;
        if (done_o !== 1'b0) begin $display("FAIL reset_done: got %0b want 0", done_o); n_fail++; end
        n_checks++;
        if (ovf_o !== 16'h0) begin $display("FAIL reset_ovf: got %h want 0", ovf_o); n_fail++; end
        n_checks++;
        if (psum_row_o !== 640'h0) begin $display("FAIL reset_row: got %h want 0", psum_row_o); n_fail++; end
        n_checks++;
        if (s_busy !== 1'b0 || s_ovf !== 2'b00) begin $display("FAIL reset_small: busy %0b ovf %b want 0 00", s_busy, s_ovf); n_fail++; end
        n_checks++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        start_job(7'd4, 8'd1);
        if (busy_o !== 1'b1) begin $display("FAIL sp_busy: got %0b want 1", busy_o); n_fail++; end
        n_checks++;
        psum_en_i = '1;
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < 16; j++) set_psum(j, 32'(k));
            tick();
        end
        psum_en_i = '0;
        if (out_valid_o !== 1'b0) begin $display("FAIL sp_valid_early: got %0b want 0", out_valid_o); n_fail++; end
        n_checks++;
        tick();
        if (out_valid_o !== 1'b1) begin $display("FAIL sp_valid: got %0b want 1", out_valid_o); n_fail++; end
        n_checks++;
        out_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < 16; j++) lane_val[j] = 40'(k);
            exp_row = pack_row();
            if (psum_row_o !== exp_row) begin $display("FAIL sp_row%0d: got %h want %h", k, psum_row_o, exp_row); n_fail++; end
            n_checks++;
            tick();
        end
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin $display("FAIL sp_done: done %0b busy %0b want 1 0", done_o, busy_o); n_fail++; end
        n_checks++;
        if (out_valid_o !== 1'b0 || psum_row_o !== 640'h0) begin $display("FAIL sp_idle_row: valid %0b row %h want 0", out_valid_o, psum_row_o); n_fail++; end
        n_checks++;
        tick();
        if (done_o !== 1'b0) begin $display("FAIL sp_done_pulse: got %0b want 0", done_o); n_fail++; end
        n_checks++;
    endtask

    task automatic test_multi_pass();
        start_job(7'd2, 8'd3);
        psum_en_i = '1;
        for (int p = 0; p < 3; p++) begin
            set_psum(0, 32'd5);
            for (int j = 1; j < 16; j++) set_psum(j, 32'd1);
            tick();
            set_psum(0, -32'sd7);
            for (int j = 1; j < 16; j++) set_psum(j, 32'd2);
            tick();
        end
        psum_en_i = '0;
        tick();
        out_ready_i = 1'b1;
        lane_val[0] = 40'sd15;
        for (int j = 1; j < 16; j++) lane_val[j] = 40'sd3;
        exp_row = pack_row();
        if (out_valid_o !== 1'b1 || psum_row_o !== exp_row) begin $display("FAIL mp_row0: valid %0b got %h want %h", out_valid_o, psum_row_o, exp_row); n_fail++; end
        n_checks++;
        tick();
        lane_val[0] = -40'sd21;
        for (int j = 1; j < 16; j++) lane_val[j] = 40'sd6;
        exp_row = pack_row();
        if (psum_row_o !== exp_row) begin $display("FAIL mp_row1: got %h want %h", psum_row_o, exp_row); n_fail++; end
        n_checks++;
        if (ovf_o !== 16'h0) begin $display("FAIL mp_ovf: got %h want 0", ovf_o); n_fail++; end
        n_checks++;
        tick();
        if (done_o !== 1'b1) begin $display("FAIL mp_done: got %0b want 1", done_o); n_fail++; end
        n_checks++;
        tick();
    endtask

    task automatic test_skew();
        start_job(7'd3, 8'd2);
        for (int c = 0; c < 21; c++) begin
            for (int j = 0; j < 16; j++) begin
                int k;
                k = c - j;
                if (k < 0) begin
                    psum_en_i[j] = 1'b0;
                    set_psum(j, 32'd0);
                end else if (k < 6) begin
                    psum_en_i[j] = 1'b1;
                    set_psum(j, 32'(j*16 + k + 1));
                end else begin
                    psum_en_i[j] = 1'b1;
                    set_psum(j, 32'd1000);
                end
            end
            tick();
            if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin $display("FAIL skew_accum_c%0d: valid %0b busy %0b want 0 1", c, out_valid_o, busy_o); n_fail++; end
            n_checks++;
        end
        out_ready_i = 1'b1;
        tick();
        if (out_valid_o !== 1'b1) begin $display("FAIL skew_drain_entry: got %0b want 1", out_valid_o); n_fail++; end
        n_checks++;
        for (int e = 0; e < 3; e++) begin
            for (int j = 0; j < 16; j++) lane_val[j] = 40'(32*j + 2*e + 5);
            exp_row = pack_row();
            if (psum_row_o !== exp_row) begin $display("FAIL skew_row%0d: got %h want %h", e, psum_row_o, exp_row); n_fail++; end
            n_checks++;
            tick();
        end
        psum_en_i = '0;
        if (done_o !== 1'b1) begin $display("FAIL skew_done: got %0b want 1", done_o); n_fail++; end
        n_checks++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [639:0] row0;
        start_job(7'd2, 8'd1);
        psum_en_i = '1;
        for (int j = 0; j < 16; j++) set_psum(j, 32'(j + 100));
        tick();
        for (int j = 0; j < 16; j++) set_psum(j, 32'(j + 200));
        tick();
        psum_en_i = '0;
        out_ready_i = 1'b0;
        tick();
        for (int j = 0; j < 16; j++) lane_val[j] = 40'(j + 100);
        row0 = pack_row();
        for (int h = 0; h < 5; h++) begin
            start_i = 1'b1; len_i = 7'd1; num_pass_i = 8'd1;
            if (out_valid_o !== 1'b1 || psum_row_o !== row0) begin $display("FAIL bp_hold%0d: valid %0b got %h want %h", h, out_valid_o, psum_row_o, row0); n_fail++; end
            n_checks++;
            tick();
        end
        start_i = 1'b0;
        if (psum_row_o !== row0 || busy_o !== 1'b1) begin $display("FAIL bp_hold_end: busy %0b got %h want %h", busy_o, psum_row_o, row0); n_fail++; end
        n_checks++;
        out_ready_i = 1'b1;
        tick();
        for (int j = 0; j < 16; j++) lane_val[j] = 40'(j + 200);
        exp_row = pack_row();
        if (out_valid_o !== 1'b1 || psum_row_o !== exp_row) begin $display("FAIL bp_row1: valid %0b got %h want %h", out_valid_o, psum_row_o, exp_row); n_fail++; end
        n_checks++;
        tick();
        if (done_o !== 1'b1 || out_valid_o !== 1'b0) begin $display("FAIL bp_done: done %0b valid %0b want 1 0", done_o, out_valid_o); n_fail++; end
        n_checks++;
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] exp0;
`ifdef ACC_BANK_SAT_EN
        exp0 = 8'd127;
`else
        exp0 = 8'hC8;
`endif
        s_start = 1'b1; s_len = 3'd1; s_np = 8'd2;
        tick();
        s_start = 1'b0;
        s_en = 2'b11;
        s_psum = {8'd100, 8'd1};
        tick();
        tick();
        s_en = 2'b00;
        if (s_ovf !== 2'b01) begin $display("FAIL ovf_flag: got %b want 01", s_ovf); n_fail++; end
        n_checks++;
        tick();
        if (s_valid !== 1'b1 || s_row !== {exp0, 8'd2}) begin $display("FAIL ovf_row: valid %0b got %h want %h", s_valid, s_row, {exp0, 8'd2}); n_fail++; end
        n_checks++;
        s_ready = 1'b1;
        tick();
        if (s_done !== 1'b1) begin $display("FAIL ovf_done: got %0b want 1", s_done); n_fail++; end
        n_checks++;
        tick();
    endtask

    task automatic test_abort();
        start_job(7'd2, 8'd1);
        psum_en_i = '1;
        for (int j = 0; j < 16; j++) set_psum(j, 32'd3);
        tick();
        psum_en_i = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || out_valid_o !== 1'b0) begin $display("FAIL abort_state: busy %0b done %0b valid %0b want 0 0 0", busy_o, done_o, out_valid_o); n_fail++; end
        n_checks++;
        tick();
        if (done_o !== 1'b0) begin $display("FAIL abort_no_done: got %0b want 0", done_o); n_fail++; end
        n_checks++;
        start_job(7'd1, 8'd1);
        psum_en_i = '1;
        for (int j = 0; j < 16; j++) set_psum(j, 32'd9);
        tick();
        psum_en_i = '0;
        tick();
        for (int j = 0; j < 16; j++) lane_val[j] = 40'sd9;
        exp_row = pack_row();
        if (psum_row_o !== exp_row || done_o !== 1'b0) begin $display("FAIL abort_row: done %0b got %h want %h", done_o, psum_row_o, exp_row); n_fail++; end
        n_checks++;
        if (ovf_o !== 16'h0) begin $display("FAIL abort_ovf: got %h want 0", ovf_o); n_fail++; end
        n_checks++;
        out_ready_i = 1'b1;
        tick();
        if (done_o !== 1'b1) begin $display("FAIL abort_done: got %0b want 1", done_o); n_fail++; end
        n_checks++;
        tick();
    endtask

    task automatic test_bad_start();
        start_job(7'd0, 8'd1);
        if (busy_o !== 1'b0) begin $display("FAIL bad_len0: busy %0b want 0", busy_o); n_fail++; end
        n_checks++;
        start_job(7'd65, 8'd1);
        if (busy_o !== 1'b0) begin $display("FAIL bad_len65: busy %0b want 0", busy_o); n_fail++; end
        n_checks++;
        start_job(7'd1, 8'd0);
        if (busy_o !== 1'b1 || out_valid_o !== 1'b0) begin $display("FAIL np0_accum: busy %0b valid %0b want 1 0", busy_o, out_valid_o); n_fail++; end
        n_checks++;
        psum_en_i = '1;
        for (int j = 0; j < 16; j++) set_psum(j, 32'd11);
        tick();
        psum_en_i = '0;
        tick();
        for (int j = 0; j < 16; j++) lane_val[j] = 40'sd11;
        exp_row = pack_row();
        if (out_valid_o !== 1'b1 || psum_row_o !== exp_row) begin $display("FAIL np0_row: valid %0b got %h want %h", out_valid_o, psum_row_o, exp_row); n_fail++; end
        n_checks++;
        out_ready_i = 1'b1;
        tick();
        if (done_o !== 1'b1) begin $display("FAIL np0_done: got %0b want 1", done_o); n_fail++; end
        n_checks++;
        tick();
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; num_pass_i = '0; len_i = '0;
        psum_en_i = '0; psum_row_i = '0; out_ready_i = 1'b0;
        s_start = 1'b0; s_np = '0; s_len = '0; s_en = '0; s_psum = '0; s_ready = 1'b0;
        for (int j = 0; j < 16; j++) lane_val[j] = '0;
        exp_row = '0;

        test_reset();
        test_single_pass();
        test_multi_pass();
        test_skew();
        test_backpressure();
        test_overflow();
        test_abort();
        test_bad_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
